// File: rtl/shifter.sv
// shifter: four-channel waveform mixer. Each 8-bit channel pattern is latched
// at frame start and played back MSB first, one bit every STEP_DIV clocks.
// The active channels are summed into a saturating 8-bit amplitude.
module shifter #(
  parameter int unsigned STEP_DIV = 4,
  parameter int unsigned AMP      = 63
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] Chl1,
  input  logic [7:0] Chl2,
  input  logic [7:0] Chl3,
  input  logic [7:0] Chl4,
  output logic [7:0] sound_out
);

  localparam int unsigned DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [DW-1:0] div;
  logic [2:0]    phase;
  logic [7:0]    shadow1, shadow2, shadow3, shadow4;
  logic          frame;
  logic [7:0]    sel1, sel2, sel3, sel4;
  logic [2:0]    n;
  logic [15:0]   sum;

  assign frame = (phase == 3'd0) && (div == '0);

  // Step divider and bit-phase counter; phase advances on each divider wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div   <= '0;
      phase <= '0;
    end else if (div == DW'(STEP_DIV - 1)) begin
      div   <= '0;
      phase <= phase + 3'd1;
    end else begin
      div   <= div + DW'(1);
    end
  end

  // Latch the channel patterns once per frame so mid-frame changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow1 <= '0;
      shadow2 <= '0;
      shadow3 <= '0;
      shadow4 <= '0;
    end else if (frame) begin
      shadow1 <= Chl1;
      shadow2 <= Chl2;
      shadow3 <= Chl3;
      shadow4 <= Chl4;
    end
  end

  // Pick the live inputs on the frame-start clock so phase 0 of a new frame
  // already uses the new pattern, then count the active bits at this phase
  always_comb begin
    sel1 = frame ? Chl1 : shadow1;
    sel2 = frame ? Chl2 : shadow2;
    sel3 = frame ? Chl3 : shadow3;
    sel4 = frame ? Chl4 : shadow4;
    n    = 3'(sel1[3'd7 - phase]) + 3'(sel2[3'd7 - phase])
         + 3'(sel3[3'd7 - phase]) + 3'(sel4[3'd7 - phase]);
    sum  = 16'(n) * 16'(AMP);
  end

  // Registered, saturating mix output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sound_out <= '0;
    end else begin
      sound_out <= (sum > 16'd255) ? 8'hFF : sum[7:0];
    end
  end

endmodule

// File: tb/tb_shifter.sv
// tb_shifter: three shifter instances with different STEP_DIV/AMP share the
// same inputs; each is compared every clock against a frame/phase model.
module tb_shifter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] chl1, chl2, chl3, chl4;
  logic [7:0] out_a, out_b, out_c;

  always #5 clk = ~clk;

  shifter #(.STEP_DIV(4), .AMP(63)) u_a (
    .clk(clk), .rst_n(rst_n), .Chl1(chl1), .Chl2(chl2), .Chl3(chl3), .Chl4(chl4),
    .sound_out(out_a));
  shifter #(.STEP_DIV(2), .AMP(63)) u_b (
    .clk(clk), .rst_n(rst_n), .Chl1(chl1), .Chl2(chl2), .Chl3(chl3), .Chl4(chl4),
    .sound_out(out_b));
  shifter #(.STEP_DIV(1), .AMP(70)) u_c (
    .clk(clk), .rst_n(rst_n), .Chl1(chl1), .Chl2(chl2), .Chl3(chl3), .Chl4(chl4),
    .sound_out(out_c));

  int unsigned sd  [3] = '{4, 2, 1};
  int unsigned amp [3] = '{63, 63, 70};
  logic [7:0]  lat [3][4];
  int unsigned t;
  int unsigned expv [3];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t);
    end
  endtask

  // Reference: clock t after reset release plays bit (7 - (t/sd)%8) of the
  // pattern captured at the most recent multiple of 8*sd.
  task automatic model_edge();
    logic [7:0]  in [4];
    int unsigned ph, cnt, s;
    in = '{chl1, chl2, chl3, chl4};
    for (int i = 0; i < 3; i++) begin
      if (t % (8 * sd[i]) == 0) lat[i] = in;
      ph  = (t / sd[i]) % 8;
      cnt = 0;
      for (int k = 0; k < 4; k++) cnt += lat[i][k][7 - ph];
      s = cnt * amp[i];
      expv[i] = (s > 255) ? 255 : s;
    end
    t++;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    else begin
      t = 0;
      expv = '{0, 0, 0};
    end
    @(negedge clk);
    chk("out_a", 32'(out_a), 32'(expv[0]));
    chk("out_b", 32'(out_b), 32'(expv[1]));
    chk("out_c", 32'(out_c), 32'(expv[2]));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_in(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
    chl1 = a; chl2 = b; chl3 = c; chl4 = d;
  endtask

  // Assert reset between edges, verify the immediate drop, hold, release
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a", 32'(out_a), 32'd0);
    chk("async_rst_b", 32'(out_b), 32'd0);
    chk("async_rst_c", 32'(out_c), 32'd0);
    run(3);
    rst_n = 1'b1;
  endtask

  initial begin
    t = 0;
    set_in(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    @(negedge clk);
    chk("reset_a", 32'(out_a), 32'd0);
    run(4);
    rst_n = 1'b1;

    // Single constant channel, then silence
    set_in(8'h00, 8'h00, 8'h00, 8'hFF);
    run(40);
    chk("const63_a", 32'(out_a), 32'd63);
    set_in(8'h00, 8'h00, 8'h00, 8'h00);
    run(40);

    // Mid-frame update on clock 10 of a u_a frame
    set_in(8'h00, 8'h00, 8'h00, 8'hFF);
    for (int i = 0; i < 64; i++) begin
      if (t % 32 == 10) break;
      cycle();
    end
    chl3 = 8'hAA;
    run(64);

    // Full mix and saturation
    set_in(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    run(40);
    chk("full_a", 32'(out_a), 32'd252);
    chk("sat_c", 32'(out_c), 32'd255);

    // Bit order and step rate
    set_in(8'h80, 8'h00, 8'h00, 8'h00);
    run(48);

    // Reset mid-frame at u_b phase 3
    set_in(8'h0F, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 32; i++) begin
      if (t % 16 == 6) break;
      cycle();
    end
    async_reset();
    run(32);

    // Randomised input changes at arbitrary times, occasional resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(3))
          0: chl1 = 8'($urandom);
          1: chl2 = 8'($urandom);
          2: chl3 = 8'($urandom);
          default: chl4 = 8'($urandom);
        endcase
      end
      if ($urandom_range(150) == 0) async_reset();
      else cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
